// File: rtl/t_clkq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : t_clkq_pkg
//  Description : Shared state encoding, default constants and helpers for the
//                t_clkq+t_setup ring-measurement sequencer.
//  Revision    : 1.0
// ============================================================================
package t_clkq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_START  = 2'd1,
        ST_WINDOW = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int CNT_WIDTH_DEF = 8;
    localparam int N_DEF         = 16;
    localparam int WINDOW_DEF    = 128;
    localparam int RUNS_LOG2_DEF = 2;
    localparam int ERR_WIDTH_DEF = 8;

    // Increment that sticks at max_val instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                            input logic [31:0] max_val);
        return (val >= max_val) ? val : val + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/t_clkq_lap_checker.sv
`default_nettype none
// ============================================================================
//  Module      : t_clkq_lap_checker
//  Description : Ring tap edge detector with lap counter and a saturating
//                error counter for early, late or missing laps.
//  Revision    : 1.0
// ============================================================================
module t_clkq_lap_checker
    import t_clkq_pkg::*;
#(
    parameter int N         = N_DEF,
    parameter int LAPS_W    = CNT_WIDTH_DEF + RUNS_LOG2_DEF,
    parameter int ERR_WIDTH = ERR_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 start,
    input  logic                 en,
    input  logic                 ring_tap,
    output logic [LAPS_W-1:0]    laps,
    output logic [ERR_WIDTH-1:0] err
);

    localparam int                   c_GAP_W   = (N > 1) ? $clog2(N) : 1;
    localparam logic [c_GAP_W-1:0]   c_GAP_END = c_GAP_W'(N - 1);
    localparam logic [ERR_WIDTH-1:0] c_ERR_MAX = '1;

    logic                 r_tap_prev;
    logic [c_GAP_W-1:0]   r_gap;
    logic [LAPS_W-1:0]    r_laps;
    logic [ERR_WIDTH-1:0] r_err;
    logic                 w_rise;
    logic                 w_gap_end;
    logic [ERR_WIDTH-1:0] w_err_inc;

    assign w_rise    = ring_tap & ~r_tap_prev;
    assign w_gap_end = (r_gap == c_GAP_END);
    assign w_err_inc = ERR_WIDTH'(sat_inc(32'(r_err), 32'(c_ERR_MAX)));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_tap_prev <= 1'b0;
            r_gap      <= '0;
            r_laps     <= '0;
            r_err      <= '0;
        end else if (start) begin
            r_tap_prev <= 1'b0;
            r_gap      <= '0;
        end else if (en) begin
            r_tap_prev <= ring_tap;
            if (w_rise)
                r_laps <= r_laps + LAPS_W'(1);
            // A lap edge must land exactly on gap N-1; anything else is an error.
            if (w_rise != w_gap_end)
                r_err <= w_err_inc;
            if (w_rise || w_gap_end)
                r_gap <= '0;
            else
                r_gap <= r_gap + c_GAP_W'(1);
        end
    end

    assign laps = r_laps;
    assign err  = r_err;

endmodule
`default_nettype wire

// File: rtl/t_clkq_measure_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : t_clkq_measure_sequencer
//  Description : Runs 2^RUNS_LOG2 start/window measurement runs per request
//                and reports averaged delta, lap count and lap error count.
//  Revision    : 1.0
// ============================================================================
module t_clkq_measure_sequencer
    import t_clkq_pkg::*;
#(
    parameter int CNT_WIDTH = CNT_WIDTH_DEF,
    parameter int N         = N_DEF,
    parameter int WINDOW    = WINDOW_DEF,
    parameter int RUNS_LOG2 = RUNS_LOG2_DEF,
    parameter int ERR_WIDTH = ERR_WIDTH_DEF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           req_valid,
    output logic                           req_ready,
    output logic                           meas_start,
    input  logic [CNT_WIDTH-1:0]           meas_cnt,
    input  logic                           ring_tap,
    output logic                           res_valid,
    input  logic                           res_ready,
    output logic [CNT_WIDTH-1:0]           res_delta,
    output logic [CNT_WIDTH+RUNS_LOG2-1:0] res_laps,
    output logic [ERR_WIDTH-1:0]           res_err,
    output logic                           busy
);

    localparam int                    c_ACC_W    = CNT_WIDTH + RUNS_LOG2;
    localparam int                    c_RIDX_W   = (RUNS_LOG2 > 0) ? RUNS_LOG2 : 1;
    localparam logic [c_RIDX_W-1:0]   c_RUN_LAST = c_RIDX_W'((1 << RUNS_LOG2) - 1);
    localparam logic [CNT_WIDTH-1:0]  c_WIN_LAST = CNT_WIDTH'(WINDOW - 1);

    state_t               r_state;
    logic [c_RIDX_W-1:0]  r_run_idx;
    logic [CNT_WIDTH-1:0] r_cnt0;
    logic [CNT_WIDTH-1:0] r_win_cnt;
    logic [c_ACC_W-1:0]   r_acc;
    logic                 r_meas_start;
    logic                 r_res_valid;
    logic [CNT_WIDTH-1:0] w_delta;
    logic                 w_accept;

    assign w_accept = (r_state == ST_IDLE) && req_valid;
    // Modular subtraction absorbs a counter wrap inside the window.
    assign w_delta  = meas_cnt - r_cnt0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_run_idx    <= '0;
            r_cnt0       <= '0;
            r_win_cnt    <= '0;
            r_acc        <= '0;
            r_meas_start <= 1'b0;
            r_res_valid  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_acc        <= '0;
                        r_run_idx    <= '0;
                        r_meas_start <= 1'b1;
                        r_state      <= ST_START;
                    end
                end
                ST_START: begin
                    r_meas_start <= 1'b0;
                    r_cnt0       <= meas_cnt;
                    r_win_cnt    <= '0;
                    r_state      <= ST_WINDOW;
                end
                ST_WINDOW: begin
                    r_win_cnt <= r_win_cnt + CNT_WIDTH'(1);
                    if (r_win_cnt == c_WIN_LAST) begin
                        r_acc <= r_acc + c_ACC_W'(w_delta);
                        if (r_run_idx == c_RUN_LAST) begin
                            r_res_valid <= 1'b1;
                            r_state     <= ST_DONE;
                        end else begin
                            r_run_idx    <= r_run_idx + c_RIDX_W'(1);
                            r_meas_start <= 1'b1;
                            r_state      <= ST_START;
                        end
                    end
                end
                ST_DONE: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    t_clkq_lap_checker #(
        .N         (N),
        .LAPS_W    (c_ACC_W),
        .ERR_WIDTH (ERR_WIDTH)
    ) u_lap_checker (
        .clk      (clk),
        .rst      (rst),
        .clr      (w_accept),
        .start    (r_state == ST_START),
        .en       (r_state == ST_WINDOW),
        .ring_tap (ring_tap),
        .laps     (res_laps),
        .err      (res_err)
    );

    assign meas_start = r_meas_start;
    assign res_valid  = r_res_valid;
    assign res_delta  = CNT_WIDTH'(r_acc >> RUNS_LOG2);
    assign req_ready  = (r_state == ST_IDLE);
    assign busy       = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_t_clkq_measure_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_t_clkq_measure_sequencer
//  Description : Directed self-checking bench with a ring tap / counter model.
//  Revision    : 1.0
// ============================================================================
module tb_t_clkq_measure_sequencer;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, req_valid, res_ready, req_ready, meas_start, res_valid, busy;
    logic [7:0] meas_cnt = 8'd0;
    logic       ring_tap = 1'b0;
    logic [7:0] res_delta;
    logic [9:0] res_laps;
    logic [7:0] res_err;

    logic       req_valid2, res_ready2, req_ready2, meas_start2, res_valid2, busy2;
    logic       tap_zero = 1'b0;
    logic [7:0] res_delta2;
    logic [9:0] res_laps2;
    logic [3:0] res_err2;

    t_clkq_measure_sequencer #(.CNT_WIDTH(8), .N(16), .WINDOW(128), .RUNS_LOG2(2), .ERR_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .meas_start(meas_start), .meas_cnt(meas_cnt), .ring_tap(ring_tap),
        .res_valid(res_valid), .res_ready(res_ready), .res_delta(res_delta),
        .res_laps(res_laps), .res_err(res_err), .busy(busy));

    t_clkq_measure_sequencer #(.CNT_WIDTH(8), .N(16), .WINDOW(128), .RUNS_LOG2(2), .ERR_WIDTH(4)) dut_sat (
        .clk(clk), .rst(rst), .req_valid(req_valid2), .req_ready(req_ready2),
        .meas_start(meas_start2), .meas_cnt(meas_cnt), .ring_tap(tap_zero),
        .res_valid(res_valid2), .res_ready(res_ready2), .res_delta(res_delta2),
        .res_laps(res_laps2), .res_err(res_err2), .busy(busy2));

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Datapath model: free counter plus a tap pulse every 16 cycles after meas_start.
    int         phase = 1000;
    int         run_no = 0;
    int         start_cyc [4];
    int         drop_run = -1;
    int         drop_pulse = 0;
    logic       preset_req = 1'b0;
    logic [7:0] preset_val = 8'd0;

    always @(negedge clk) begin
        if (preset_req) meas_cnt = preset_val;
        else            meas_cnt = meas_cnt + 8'd1;
        if (meas_start) begin
            phase = 0;
            start_cyc[run_no % 4] = cyc;
            run_no = run_no + 1;
        end else begin
            phase = phase + 1;
        end
        ring_tap = (phase > 0) && (phase <= 128) && (phase % 16 == 0) &&
                   !(run_no == drop_run && phase / 16 == drop_pulse);
    end

    task automatic do_request();
        @(negedge clk) req_valid = 1'b1;
        @(negedge clk) req_valid = 1'b0;
    endtask

    task automatic wait_result(input string name);
        int n = 0;
        while (!res_valid && n < 2000) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (res_valid !== 1'b1) $display("FAIL %s_timeout: res_valid=%0b expected 1", name, res_valid);
        else passed++;
    endtask

    task automatic consume();
        @(negedge clk) res_ready = 1'b1;
        @(negedge clk) res_ready = 1'b0;
    endtask

    task automatic check_result(input string name, input int d, input int l, input int e);
        total++;
        if (res_delta !== 8'(d)) $display("FAIL %s_delta: got %0d expected %0d", name, res_delta, d);
        else passed++;
        total++;
        if (res_laps !== 10'(l)) $display("FAIL %s_laps: got %0d expected %0d", name, res_laps, l);
        else passed++;
        total++;
        if (res_err !== 8'(e)) $display("FAIL %s_err: got %0d expected %0d", name, res_err, e);
        else passed++;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; res_ready = 1'b0; req_valid2 = 1'b0; res_ready2 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (req_ready !== 1'b1 || busy !== 1'b0) $display("FAIL reset_ctrl: req_ready=%0b busy=%0b expected 1 0", req_ready, busy);
        else passed++;
        total++;
        if (meas_start !== 1'b0 || res_valid !== 1'b0) $display("FAIL reset_pulse: meas_start=%0b res_valid=%0b expected 0 0", meas_start, res_valid);
        else passed++;
        check_result("reset", 0, 0, 0);
        total++;
        if (res_err2 !== 4'd0 || req_ready2 !== 1'b1) $display("FAIL reset_sat: err=%0d req_ready=%0b expected 0 1", res_err2, req_ready2);
        else passed++;
    endtask

    task automatic test_healthy();
        int base = run_no;
        do_request();
        wait_result("healthy");
        check_result("healthy", 128, 32, 0);
        total++;
        if (run_no - base !== 4) $display("FAIL healthy_starts: got %0d expected 4", run_no - base);
        else passed++;
        total++;
        if (start_cyc[(base + 1) % 4] - start_cyc[base % 4] !== 129)
            $display("FAIL healthy_spacing01: got %0d expected 129", start_cyc[(base + 1) % 4] - start_cyc[base % 4]);
        else passed++;
        total++;
        if (start_cyc[(base + 3) % 4] - start_cyc[(base + 2) % 4] !== 129)
            $display("FAIL healthy_spacing23: got %0d expected 129", start_cyc[(base + 3) % 4] - start_cyc[(base + 2) % 4]);
        else passed++;
        consume();
    endtask

    task automatic test_wrap();
        @(posedge clk) begin preset_val = 8'd200; preset_req = 1'b1; end
        @(posedge clk) preset_req = 1'b0;
        do_request();
        wait_result("wrap");
        check_result("wrap", 128, 32, 0);
        consume();
    endtask

    task automatic test_missing();
        drop_run = run_no + 2;
        drop_pulse = 3;
        do_request();
        wait_result("missing");
        check_result("missing", 128, 31, 1);
        consume();
        drop_run = -1;
    endtask

    task automatic test_backpressure();
        int bad = 0;
        do_request();
        wait_result("bp");
        req_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (res_valid !== 1'b1 || res_delta !== 8'd128 || res_laps !== 10'd32 || res_err !== 8'd0 ||
                req_ready !== 1'b0 || busy !== 1'b1 || meas_start !== 1'b0) bad++;
        end
        total++;
        if (bad != 0) $display("FAIL bp_hold: %0d unstable cycles, expected 0", bad);
        else passed++;
        res_ready = 1'b1;
        @(negedge clk) res_ready = 1'b0;
        total++;
        if (res_valid !== 1'b0 || req_ready !== 1'b1 || meas_start !== 1'b0)
            $display("FAIL bp_release: res_valid=%0b req_ready=%0b meas_start=%0b expected 0 1 0", res_valid, req_ready, meas_start);
        else passed++;
        @(negedge clk) req_valid = 1'b0;
        total++;
        if (meas_start !== 1'b1 || busy !== 1'b1) $display("FAIL bp_reaccept: meas_start=%0b busy=%0b expected 1 1", meas_start, busy);
        else passed++;
        wait_result("bp2");
        check_result("bp2", 128, 32, 0);
        consume();
    endtask

    task automatic test_reset_mid();
        int base = run_no;
        int n = 0;
        do_request();
        while (!(run_no == base + 1 && phase == 51) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (!(run_no == base + 1 && phase == 51)) $display("FAIL rstmid_reach: phase=%0d expected 51", phase);
        else passed++;
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        total++;
        if (req_ready !== 1'b1 || busy !== 1'b0 || meas_start !== 1'b0 || res_valid !== 1'b0)
            $display("FAIL rstmid_idle: req_ready=%0b busy=%0b meas_start=%0b res_valid=%0b expected 1 0 0 0",
                     req_ready, busy, meas_start, res_valid);
        else passed++;
        total++;
        if (res_laps !== 10'd0) $display("FAIL rstmid_laps: got %0d expected 0", res_laps);
        else passed++;
        do_request();
        wait_result("rstmid");
        check_result("rstmid", 128, 32, 0);
        consume();
    endtask

    task automatic test_saturation();
        int n = 0;
        @(negedge clk) req_valid2 = 1'b1;
        @(negedge clk) req_valid2 = 1'b0;
        while (!res_valid2 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (res_valid2 !== 1'b1) $display("FAIL sat_timeout: res_valid=%0b expected 1", res_valid2);
        else passed++;
        total++;
        if (res_err2 !== 4'd15) $display("FAIL sat_err: got %0d expected 15", res_err2);
        else passed++;
        total++;
        if (res_laps2 !== 10'd0) $display("FAIL sat_laps: got %0d expected 0", res_laps2);
        else passed++;
        total++;
        if (res_delta2 !== 8'd128) $display("FAIL sat_delta: got %0d expected 128", res_delta2);
        else passed++;
        @(negedge clk) res_ready2 = 1'b1;
        @(negedge clk) res_ready2 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_healthy();
        test_wrap();
        test_missing();
        test_backpressure();
        test_reset_mid();
        test_saturation();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
